// File: rtl/prio_encoder_rr_pkg.sv
// Shared constants and types for the registered round-robin priority encoder.
// Imported by the selector, the top level and the bench.
package prio_encoder_rr_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE,
        HOLD
    } state_e;

endpackage

// File: rtl/prio_encoder_rr_if.sv
// Request/grant bundle between the request sources, the encoder and the consumer.
// The slave side is the encoder.
interface prio_encoder_rr_if #(
    parameter int N = 4
);
    localparam int W = $clog2(N);

    logic         en;
    logic         mode;
    logic [N-1:0] req;
    logic [W-1:0] out_idx;
    logic         out_valid;
    logic         out_ack;
    logic         multi;
    logic [W-1:0] last_idx;

    modport master (
        output en, mode, req, out_ack,
        input  out_idx, out_valid, multi, last_idx
    );

    modport slave (
        input  en, mode, req, out_ack,
        output out_idx, out_valid, multi, last_idx
    );

endinterface

// File: rtl/prio_encoder_rr_prio_sel.sv
// Combinational selector: first set request searching downward from start-1, wrapping mod N.
// Fixed mode searches from 0, which makes the order N-1 down to 0.
module prio_sel
    import prio_encoder_rr_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    input  logic                 mode_i,
    output logic [$clog2(N)-1:0] idx_o,
    output logic                 any_o
);
    localparam int W = $clog2(N);

    always_comb begin
        logic found;
        int   base;
        int   c;
        idx_o = '0;
        any_o = |req_i;
        found = 1'b0;
        base  = (mode_i == MODE_RR) ? int'(start_i) : 0;
        c     = 0;
        // Wrap explicitly to N-1 so non-power-of-two N never yields idx >= N
        for (int k = 1; k <= N; k++) begin
            c = base - k;
            if (c < 0) c = c + N;
            if (!found && req_i[c]) begin
                found = 1'b1;
                idx_o = W'(c);
            end
        end
    end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered N-input priority encoder with valid/ack handshake,
// fixed or round-robin selection and a last-acked pointer.
module prio_encoder_rr
    import prio_encoder_rr_pkg::*;
#(
    parameter int N = 4
) (
    input logic            clk,
    input logic            rst,
    prio_encoder_rr_if.slave bus
);
    localparam int W = $clog2(N);

    state_e       state_q;
    logic [W-1:0] idx_q;
    logic [W-1:0] last_q;
    logic         valid_q;
    logic         multi_q;

    logic [W-1:0] ptr;
    logic [W-1:0] idx_d;
    logic         any;
    logic         multi_d;
    logic         load;

    // On an ack the search must start from the index being acked
    assign ptr = (state_q == HOLD) ? idx_q : last_q;

    prio_sel #(.N(N)) u_sel (
        .req_i   (bus.req),
        .start_i (ptr),
        .mode_i  (bus.mode),
        .idx_o   (idx_d),
        .any_o   (any)
    );

    assign multi_d = |(bus.req & (bus.req - N'(1)));
    assign load    = bus.en && any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            last_q  <= '0;
            valid_q <= 1'b0;
            multi_q <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (load) begin
                        idx_q   <= idx_d;
                        multi_q <= multi_d;
                        valid_q <= 1'b1;
                        state_q <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ack) begin
                        last_q <= idx_q;
                        if (load) begin
                            idx_q   <= idx_d;
                            multi_q <= multi_d;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.out_idx   = idx_q;
    assign bus.out_valid = valid_q;
    assign bus.multi     = multi_q;
    assign bus.last_idx  = last_q;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: N=4 and N=5 instances, scoreboard of expected grants.
module tb_prio_encoder_rr;
    import prio_encoder_rr_pkg::*;

    typedef struct {
        logic [2:0] idx;
        logic       multi;
    } exp_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    exp_t sb[$];

    prio_encoder_rr_if #(.N(4)) if4 ();
    prio_encoder_rr_if #(.N(5)) if5 ();

    prio_encoder_rr #(.N(4)) u4 (
        .clk (clk),
        .rst (rst),
        .bus (if4.slave)
    );

    prio_encoder_rr #(.N(5)) u5 (
        .clk (clk),
        .rst (rst),
        .bus (if5.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t sb_pop();
        exp_t e;
        e.idx   = 3'bxxx;
        e.multi = 1'bx;
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if (if4.out_valid !== 1'b0) begin
            bad++; $display("FAIL rst_valid got %0b want 0", if4.out_valid);
        end
        total++;
        if (if4.out_idx !== 2'd0 || if4.last_idx !== 2'd0 || if4.multi !== 1'b0) begin
            bad++;
            $display("FAIL rst_regs got idx=%0d last=%0d multi=%0b want 0/0/0",
                     if4.out_idx, if4.last_idx, if4.multi);
        end
        total++;
        if (if5.out_valid !== 1'b0 || if5.last_idx !== 3'd0) begin
            bad++; $display("FAIL rst_n5 got v=%0b last=%0d want 0/0", if5.out_valid, if5.last_idx);
        end
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_onehot();
        exp_t e;
        if4.mode = MODE_FIXED;
        if4.en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if4.req = 4'(1 << i);
            sb.push_back('{idx: 3'(i), multi: 1'b0});
            #1;
            total++;
            if (if4.out_valid !== 1'b0) begin
                bad++; $display("FAIL onehot_pre%0d got v=%0b want 0", i, if4.out_valid);
            end
            tick();
            e = sb_pop();
            total++;
            if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.multi !== e.multi) begin
                bad++;
                $display("FAIL onehot%0d got v=%0b idx=%0d m=%0b want 1/%0d/%0b",
                         i, if4.out_valid, if4.out_idx, if4.multi, e.idx, e.multi);
            end
            if4.req     = '0;
            if4.out_ack = 1'b1;
            tick();
            if4.out_ack = 1'b0;
            total++;
            if (if4.out_valid !== 1'b0 || if4.last_idx !== 2'(i)) begin
                bad++;
                $display("FAIL onehot_ack%0d got v=%0b last=%0d want 0/%0d",
                         i, if4.out_valid, if4.last_idx, i);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        if4.mode = MODE_FIXED;
        if4.req  = 4'b1011;
        sb.push_back('{idx: 3'd3, multi: 1'b1});
        tick();
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.multi !== e.multi) begin
            bad++;
            $display("FAIL fixed got v=%0b idx=%0d m=%0b want 1/%0d/%0b",
                     if4.out_valid, if4.out_idx, if4.multi, e.idx, e.multi);
        end
        if4.out_ack = 1'b1;
        sb.push_back('{idx: 3'd3, multi: 1'b1});
        tick();
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.last_idx !== 2'd3) begin
            bad++;
            $display("FAIL b2b got v=%0b idx=%0d last=%0d want 1/%0d/3",
                     if4.out_valid, if4.out_idx, if4.last_idx, e.idx);
        end
        if4.req = '0;
        tick();
        if4.out_ack = 1'b0;
        total++;
        if (if4.out_valid !== 1'b0) begin
            bad++; $display("FAIL b2b_end got v=%0b want 0", if4.out_valid);
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int   seq[4];
        int   prev;
        seq = '{2, 1, 0, 3};
        rst = 1'b1;
        tick();
        rst      = 1'b0;
        if4.mode = MODE_RR;
        if4.en   = 1'b1;
        if4.req  = 4'b1111;
        sb.push_back('{idx: 3'd3, multi: 1'b1});
        tick();
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.multi !== e.multi) begin
            bad++;
            $display("FAIL rr_first got v=%0b idx=%0d m=%0b want 1/%0d/%0b",
                     if4.out_valid, if4.out_idx, if4.multi, e.idx, e.multi);
        end
        prev        = 3;
        if4.out_ack = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sb.push_back('{idx: 3'(seq[i]), multi: 1'b1});
            tick();
            e = sb_pop();
            total++;
            if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.last_idx !== 2'(prev)) begin
                bad++;
                $display("FAIL rr%0d got v=%0b idx=%0d last=%0d want 1/%0d/%0d",
                         i, if4.out_valid, if4.out_idx, if4.last_idx, e.idx, prev);
            end
            prev = seq[i];
        end
        if4.req = '0;
        tick();
        if4.out_ack = 1'b0;
        total++;
        if (if4.out_valid !== 1'b0 || if4.last_idx !== 2'd3) begin
            bad++;
            $display("FAIL rr_end got v=%0b last=%0d want 0/3", if4.out_valid, if4.last_idx);
        end
    endtask

    task automatic test_hold_en();
        exp_t e;
        if4.mode = MODE_FIXED;
        if4.en   = 1'b1;
        if4.req  = 4'b0100;
        sb.push_back('{idx: 3'd2, multi: 1'b0});
        tick();
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.multi !== e.multi) begin
            bad++;
            $display("FAIL hold_load got v=%0b idx=%0d want 1/%0d", if4.out_valid, if4.out_idx, e.idx);
        end
        if4.req  = '0;
        if4.en   = 1'b0;
        if4.mode = MODE_RR;
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (if4.out_valid !== 1'b1 || if4.out_idx !== 2'd2) begin
                bad++;
                $display("FAIL hold%0d got v=%0b idx=%0d want 1/2", i, if4.out_valid, if4.out_idx);
            end
        end
        if4.out_ack = 1'b1;
        tick();
        if4.out_ack = 1'b0;
        if4.req     = 4'b0001;
        total++;
        if (if4.out_valid !== 1'b0 || if4.last_idx !== 2'd2) begin
            bad++;
            $display("FAIL hold_ack got v=%0b last=%0d want 0/2", if4.out_valid, if4.last_idx);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (if4.out_valid !== 1'b0) begin
                bad++; $display("FAIL en_off%0d got v=%0b want 0", i, if4.out_valid);
            end
        end
        if4.req = '0;
        if4.en  = 1'b1;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        if4.mode = MODE_FIXED;
        if4.en   = 1'b1;
        if4.req  = 4'b1000;
        sb.push_back('{idx: 3'd3, multi: 1'b0});
        tick();
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0]) begin
            bad++;
            $display("FAIL mid_load got v=%0b idx=%0d want 1/%0d", if4.out_valid, if4.out_idx, e.idx);
        end
        if4.out_ack = 1'b1;
        sb.push_back('{idx: 3'd3, multi: 1'b0});
        tick();
        if4.out_ack = 1'b0;
        if4.req     = '0;
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.last_idx !== 2'd3) begin
            bad++;
            $display("FAIL mid_b2b got v=%0b idx=%0d last=%0d want 1/%0d/3",
                     if4.out_valid, if4.out_idx, if4.last_idx, e.idx);
        end
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (if4.out_valid !== 1'b0 || if4.out_idx !== 2'd0 || if4.last_idx !== 2'd0) begin
            bad++;
            $display("FAIL mid_rst got v=%0b idx=%0d last=%0d want 0/0/0",
                     if4.out_valid, if4.out_idx, if4.last_idx);
        end
        #1;
        rst      = 1'b0;
        if4.req  = 4'b0110;
        if4.mode = MODE_RR;
        sb.push_back('{idx: 3'd2, multi: 1'b1});
        tick();
        e = sb_pop();
        total++;
        if (if4.out_valid !== 1'b1 || if4.out_idx !== e.idx[1:0] || if4.multi !== e.multi) begin
            bad++;
            $display("FAIL mid_after got v=%0b idx=%0d m=%0b want 1/%0d/%0b",
                     if4.out_valid, if4.out_idx, if4.multi, e.idx, e.multi);
        end
        if4.out_ack = 1'b1;
        if4.req     = '0;
        tick();
        if4.out_ack = 1'b0;
    endtask

    task automatic test_n5_wrap();
        exp_t        e;
        logic [4:0]  reqs[4];
        exp_t        exps[4];
        reqs = '{5'b00001, 5'b10001, 5'b10001, 5'b10000};
        exps = '{'{idx: 3'd0, multi: 1'b0}, '{idx: 3'd4, multi: 1'b1},
                 '{idx: 3'd0, multi: 1'b1}, '{idx: 3'd4, multi: 1'b0}};
        if5.mode = MODE_RR;
        if5.en   = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if5.req = reqs[i];
            sb.push_back(exps[i]);
            tick();
            if5.out_ack = 1'b1;
            e = sb_pop();
            total++;
            if (if5.out_valid !== 1'b1 || if5.out_idx !== e.idx || if5.multi !== e.multi
                || if5.out_idx >= 3'd5) begin
                bad++;
                $display("FAIL n5_%0d got v=%0b idx=%0d m=%0b want 1/%0d/%0b",
                         i, if5.out_valid, if5.out_idx, if5.multi, e.idx, e.multi);
            end
        end
        if5.req = '0;
        tick();
        if5.out_ack = 1'b0;
        total++;
        if (if5.out_valid !== 1'b0 || if5.last_idx !== 3'd4) begin
            bad++;
            $display("FAIL n5_end got v=%0b last=%0d want 0/4", if5.out_valid, if5.last_idx);
        end
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst         = 1'b1;
        if4.en      = 1'b0;
        if4.mode    = MODE_FIXED;
        if4.req     = '0;
        if4.out_ack = 1'b0;
        if5.en      = 1'b0;
        if5.mode    = MODE_FIXED;
        if5.req     = '0;
        if5.out_ack = 1'b0;

        test_reset();
        test_onehot();
        test_back_to_back();
        test_round_robin();
        test_hold_en();
        test_reset_mid();
        test_n5_wrap();

        total++;
        if (sb.size() != 0) begin
            bad++; $display("FAIL sb_left got %0d want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-input priority encoder and the successor to the 4:2 combinational encoder with enable.
- Converts a request vector into a binary index with a valid/ack handshake.
- Supports two priority modes: fixed (highest index wins) and round-robin (rotates past the last granted index).
- Sits between request sources (interrupt lines, channel requests) and a single consumer that acknowledges each encoded index.

Parameters:
- N, 4, number of request inputs (N >= 2; need not be a power of two)
- W, $clog2(N), width of encoded index (derived; not overridden)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- en  input  1  enable; when 0, no new grant is loaded
- mode  input  1  0 = fixed priority, 1 = round-robin; sampled only at grant load
- req  input  N  request vector; bit i = request i
- out_idx  output  W  encoded index of the granted request
- out_valid  output  1  out_idx is valid and held
- out_ack  input  1  consumer accepts the current out_idx
- multi  output  1  more than one req bit was set when the current grant loaded
- last_idx  output  W  round-robin pointer (index of the last acknowledged grant)

Behaviour:
- Reset (async, immediate, including mid-grant): out_idx=0, out_valid=0, multi=0, last_idx=0, FSM=IDLE.
- FSM has two states, IDLE and HOLD.
- IDLE:
  - If en=1 and req!=0: load out_idx=selected index and multi=(popcount(req)>1); set out_valid=1 on the next edge; go to HOLD.
  - Otherwise stay in IDLE with out_valid=0.
- Latency: req sampled at edge k appears as out_valid=1 after edge k (one register stage).
- HOLD:
  - out_idx, multi and out_valid=1 stay stable regardless of req, en or mode changes.
  - The grant is sticky: req[idx] may drop and the grant is still held.
- Ack: out_ack=1 in HOLD at an edge means:
  - last_idx <= out_idx.
  - If en=1 and req!=0 in that cycle: load the next grant back-to-back; out_valid stays 1; stay in HOLD. The selection uses the updated pointer (out_idx being acked).
  - Else: out_valid <= 0; go to IDLE.
- out_ack in IDLE is ignored.
- Fixed mode: select the highest set index of req.
- Round-robin mode:
  - Search order is last_idx-1, last_idx-2, …, 0, N-1, …, last_idx (decrementing, wrap modulo N); the first set bit wins.
  - At reset (last_idx=0) the order is N-1 … 0, identical to fixed mode.
- last_idx updates on every ack in both modes, so switching modes is seamless.
- Wrap rule for non-power-of-two N: decrement from 0 wraps to N-1, never to 2^W-1; indices >= N are never produced.
- req bits are treated as synchronous to clk; no synchronisers inside.

Decomposition:
- Shared package: mode constants MODE_FIXED=1'b0 and MODE_RR=1'b1; FSM state enum {IDLE, HOLD}.
- One combinational sub-module, prio_sel: inputs req, start pointer and mode; outputs index and any-set flag. Reused for both fixed and round-robin selection.
- Top level holds the FSM, output registers and pointer.

Test Plan (N=4 unless noted):
- One-hot walk, mode=0, en=1, req=0001/0010/0100/1000, each acked one cycle after valid → out_idx=0,1,2,3; multi=0; out_valid rises one cycle after req.
- Fixed priority, req=1011, mode=0 → out_idx=3, multi=1. Ack with req still 1011 → back-to-back grant idx=3 again, out_valid never drops.
- Round-robin, req=1111 held, mode=1, ack every valid cycle → out_idx sequence 3,2,1,0,3; last_idx follows.
- Hold and en: grant idx=2 loaded, then req->0000 and en=0 for 5 cycles with no ack → out_idx=2, out_valid=1 stable. Ack → out_valid=0, IDLE; no new grant while en=0.
- Reset mid-grant: assert rst asynchronously in HOLD between edges → out_valid=0, out_idx=0, last_idx=0 immediately. After release with req=0110, mode=1 → idx=2.
- N=5, mode=1, req=00001, last_idx=0 → search wraps 4,3,2,1,0 → idx=0; no index 5–7 is ever produced.
